// File: rtl/pnr_adc_fifo_reader_if.sv
// pnr_adc_fifo_reader_if: FIFO read port and sys-bus signals of the ADC FIFO reader
interface pnr_adc_fifo_reader_if #(
    parameter int AW = 20
);
    logic [13:0]   fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [AW-1:0] sys_addr;
    logic [31:0]   sys_wdata;
    logic          sys_wen;
    logic          sys_ren;
    logic [31:0]   sys_rdata;
    logic          sys_ack;
    logic          sys_err;
    modport master (
        output fifo_dout, fifo_empty, sys_addr, sys_wdata, sys_wen, sys_ren,
        input  fifo_rd_en, sys_rdata, sys_ack, sys_err
    );
    modport slave (
        input  fifo_dout, fifo_empty, sys_addr, sys_wdata, sys_wen, sys_ren,
        output fifo_rd_en, sys_rdata, sys_ack, sys_err
    );
endinterface

// File: rtl/pnr_adc_fifo_reader.sv
// pnr_adc_fifo_reader: pops ADC samples through a one-word hold register and serves them on the sys bus
module pnr_adc_fifo_reader #(
    parameter int AW    = 20,
    parameter int CNT_W = 16
) (
    input logic                  ADC_CLK,
    input logic                  rst_i,
    pnr_adc_fifo_reader_if.slave bus_io
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL, S_FLUSH} state_t;
    state_t           state_q, state_d;
    logic             hold_vld_q, hold_vld_d, pop_prev_q, ack_q, err_q;
    logic [13:0]      hold_data_q, hold_data_d;
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d, und_cnt_q, und_cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rd_en, wr, rd, strobe, addr_ok, flushing, data_rd, pop, underrun;
    logic             ctrl_wr, flush_wr, clr_wr;
    logic [1:0]       idx;

    // a simultaneous read and write is treated as a write only
    assign wr       = bus_io.sys_wen;
    assign rd       = bus_io.sys_ren && !bus_io.sys_wen;
    assign strobe   = bus_io.sys_wen || bus_io.sys_ren;
    assign addr_ok  = bus_io.sys_addr[AW-1:4] == '0 && bus_io.sys_addr[1:0] == 2'b00;
    assign idx      = bus_io.sys_addr[3:2];
    assign flushing = state_q == S_FLUSH;
    assign data_rd  = rd && addr_ok && idx == 2'd0;
    assign pop      = data_rd && hold_vld_q;
    assign underrun = data_rd && !hold_vld_q && !flushing;
    assign ctrl_wr  = wr && addr_ok && idx == 2'd3;
    assign flush_wr = ctrl_wr && bus_io.sys_wdata[0] && !flushing;
    assign clr_wr   = ctrl_wr && bus_io.sys_wdata[1];

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                rd_en   = !hold_vld_q && !bus_io.fifo_empty;
                state_d = rd_en ? S_WAIT : S_IDLE;
            end
            S_WAIT:  state_d = S_FULL;
            S_FULL:  state_d = pop ? S_IDLE : S_FULL;
            default: begin
                // the last popped word lands one cycle later, so stay until that slot has passed
                rd_en   = !bus_io.fifo_empty;
                state_d = bus_io.fifo_empty && !pop_prev_q ? S_IDLE : S_FLUSH;
            end
        endcase
        if (flush_wr) state_d = S_FLUSH;
    end

    always_comb begin
        hold_data_d = state_q == S_WAIT ? bus_io.fifo_dout : hold_data_q;
        hold_vld_d  = (state_q == S_WAIT || (hold_vld_q && !pop)) && !flush_wr && !flushing;
        pop_cnt_d   = clr_wr ? '0 : (pop && !(&pop_cnt_q)) ? pop_cnt_q + CNT_W'(1) : pop_cnt_q;
        und_cnt_d   = clr_wr ? '0 : (underrun && !(&und_cnt_q)) ? und_cnt_q + CNT_W'(1) : und_cnt_q;
        rdata_d     = !(rd && addr_ok) ? '0
                    : idx == 2'd0 ? (hold_vld_q ? {1'b1, 15'b0, {2{hold_data_q[13]}}, hold_data_q} : '0)
                    : idx == 2'd1 ? {16'(und_cnt_q), 13'b0, flushing, bus_io.fifo_empty, hold_vld_q}
                    : idx == 2'd2 ? 32'(pop_cnt_q) : '0;
    end

    always_ff @(posedge ADC_CLK or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            pop_cnt_q   <= '0;
            und_cnt_q   <= '0;
            pop_prev_q  <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            pop_cnt_q   <= pop_cnt_d;
            und_cnt_q   <= und_cnt_d;
            pop_prev_q  <= rd_en;
            ack_q       <= strobe;
            err_q       <= strobe && !addr_ok;
            rdata_q     <= rdata_d;
        end
    end

    // gated so the pop strobe drops the moment reset asserts, not at the next edge
    assign bus_io.fifo_rd_en = rd_en && !rst_i;
    assign bus_io.sys_ack    = ack_q;
    assign bus_io.sys_err    = err_q;
    assign bus_io.sys_rdata  = rdata_q;
endmodule

// File: tb/tb_pnr_adc_fifo_reader.sv
// tb_pnr_adc_fifo_reader: directed and randomized checks of the ADC FIFO reader against a queue-based model
module tb_pnr_adc_fifo_reader;
    localparam int AW   = 20;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 0;
    logic rst = 1;
    int   n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;

    pnr_adc_fifo_reader_if #(.AW(AW)) bus ();
    pnr_adc_fifo_reader #(.AW(AW), .CNT_W(CW)) dut (.ADC_CLK(clk), .rst_i(rst), .bus_io(bus));

    logic [13:0]   q[$];
    logic          take = 0;
    int            pulses = 0, run = 0, max_run = 0;
    logic [AW-1:0] addrs [10] = '{20'h0, 20'h0, 20'h0, 20'h4, 20'h8, 20'hC, 20'hC, 20'h10, 20'h2, 20'h80000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_word(input logic [13:0] w);
        int v;
        v = $signed(w);
        return 32'h8000_0000 | (v & 32'hFFFF);
    endfunction

    // FIFO model: pops on a cycle where rd_en was high, data shows up during the next cycle
    initial begin
        bus.fifo_dout  = '0;
        bus.fifo_empty = 1'b1;
        forever begin
            @(posedge clk);
            #1 if (take && q.size() > 0) bus.fifo_dout = q.pop_front();
            #2 bus.fifo_empty = q.size() == 0;
        end
    end

    // reference model of the reader, evaluated and compared once per cycle on the falling edge
    logic        m_vld = 0, flushing = 0, last_pop = 0, exp_ack = 0, exp_err = 0;
    logic [13:0] m_data = 0, fetch_word = 0;
    logic [31:0] exp_rdata = 0;
    int          fetch_at = -1, cyc = 0, pop_cnt = 0, und_cnt = 0;
    always @(negedge clk) begin
        logic        exp_rd, wr, rd, ok, fl_wr;
        logic [1:0]  idx;
        logic [31:0] nrd;
        cyc++;
        take = bus.fifo_rd_en;
        if (bus.fifo_rd_en) begin
            pulses++;
            run++;
            if (run > max_run) max_run = run;
        end else run = 0;
        if (rst) begin
            m_vld = 0; fetch_at = -1; flushing = 0; last_pop = 0; pop_cnt = 0; und_cnt = 0;
            exp_ack = 0; exp_err = 0; exp_rdata = 0;
            check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
            check("rst_ack", 32'(bus.sys_ack), 0);
            check("rst_err", 32'(bus.sys_err), 0);
            check("rst_rdata", bus.sys_rdata, 0);
        end else begin
            exp_rd = flushing ? !bus.fifo_empty : !m_vld && fetch_at < 0 && !bus.fifo_empty;
            check("cyc_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
            check("cyc_ack", 32'(bus.sys_ack), 32'(exp_ack));
            if (exp_ack) begin
                check("cyc_err", 32'(bus.sys_err), 32'(exp_err));
                check("cyc_rdata", bus.sys_rdata, exp_rdata);
            end
            wr  = bus.sys_wen;
            rd  = bus.sys_ren && !bus.sys_wen;
            ok  = bus.sys_addr < 16 && bus.sys_addr % 4 == 0;
            idx = bus.sys_addr[3:2];
            nrd = 0;
            exp_ack = bus.sys_wen || bus.sys_ren;
            exp_err = exp_ack && !ok;
            if (rd && ok) begin
                if (idx == 0) begin
                    if (m_vld) begin
                        nrd = data_word(m_data);
                        m_vld = 0;
                        pop_cnt = pop_cnt < CMAX ? pop_cnt + 1 : CMAX;
                    end else if (!flushing) und_cnt = und_cnt < CMAX ? und_cnt + 1 : CMAX;
                end else if (idx == 1)
                    nrd = 32'(und_cnt) * 65536 + (flushing ? 4 : 0) + (bus.fifo_empty ? 2 : 0) + (m_vld ? 1 : 0);
                else if (idx == 2) nrd = 32'(pop_cnt);
            end
            exp_rdata = nrd;
            if (wr && ok && idx == 3 && bus.sys_wdata[1]) begin
                pop_cnt = 0;
                und_cnt = 0;
            end
            fl_wr = wr && ok && idx == 3 && bus.sys_wdata[0] && !flushing;
            if (fl_wr) begin
                flushing = 1; m_vld = 0; fetch_at = -1; last_pop = exp_rd;
            end else if (flushing) begin
                if (bus.fifo_empty && !last_pop) flushing = 0;
                last_pop = exp_rd;
            end else begin
                if (fetch_at == cyc + 1) begin
                    m_vld = 1; m_data = fetch_word; fetch_at = -1;
                end
                if (exp_rd) begin
                    fetch_at = cyc + 2;
                    fetch_word = q[0];
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic w, input logic r, input logic [AW-1:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic ack, output logic err);
        bus.sys_wen = w; bus.sys_ren = r; bus.sys_addr = a; bus.sys_wdata = d;
        @(posedge clk);
        #1 bus.sys_wen = 0;
        bus.sys_ren = 0;
        #1 rdata = bus.sys_rdata;
        ack = bus.sys_ack;
        err = bus.sys_err;
    endtask

    task automatic rd_reg(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] rdata;
        logic        ack, err;
        bus_op(0, 1, a, 0, rdata, ack, err);
        check(name, rdata, exp);
        check({name, "_ack"}, 32'(ack), 1);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        ack, err;
        logic [13:0] w [13];
        int          p0, r;
        bus.sys_wen = 0; bus.sys_ren = 0; bus.sys_addr = '0; bus.sys_wdata = '0;
        repeat (3) @(posedge clk);
        #3 rst = 0;
        cycles(1);
        // 1: three words, reads spaced 4 cycles
        p0 = pulses;
        q.push_back(14'h0005); q.push_back(14'h3FFF); q.push_back(14'h2000);
        cycles(4);
        rd_reg(0, 32'h8000_0005, "t1_d0"); cycles(3);
        rd_reg(0, 32'h8000_FFFF, "t1_d1"); cycles(3);
        rd_reg(0, 32'h8000_E000, "t1_d2");
        rd_reg(8, 32'd3, "t1_popcnt");
        cycles(2);
        check("t1_pulses", 32'(pulses - p0), 3);
        // 2: underrun on empty FIFO
        p0 = pulses;
        rd_reg(0, 0, "t2_data");
        rd_reg(4, 32'h0001_0002, "t2_status");
        check("t2_pulses", 32'(pulses - p0), 0);
        // 3: back-to-back reads
        q.push_back(14'h0123); q.push_back(14'h1ABC);
        cycles(4);
        rd_reg(0, 32'h8000_0123, "t3_first");
        rd_reg(0, 0, "t3_under");
        cycles(2);
        rd_reg(0, 32'h8000_1ABC, "t3_third");
        // 4: flush with 10 words queued
        for (int i = 0; i < 10; i++) q.push_back(14'($urandom));
        cycles(5);
        p0 = pulses;
        max_run = 0;
        bus_op(1, 0, 20'hC, 32'h1, rdata, ack, err);
        rd_reg(0, 0, "t4_data_flush");
        rd_reg(4, 32'h0002_0004, "t4_status_flushing");
        cycles(12);
        rd_reg(4, 32'h0002_0002, "t4_status_done");
        check("t4_pulses", 32'(pulses - p0), 9);
        check("t4_run", 32'(max_run), 9);
        // 5: pop counter saturation and clear on a read+write strobe
        for (int i = 0; i < 13; i++) begin
            w[i] = 14'(i * 1237 + 77);
            q.push_back(w[i]);
        end
        cycles(4);
        for (int i = 0; i < 12; i++) begin
            rd_reg(0, data_word(w[i]), "t5_data");
            cycles(3);
        end
        rd_reg(8, CMAX, "t5_popcnt_sat");
        bus_op(1, 1, 20'hC, 32'h2, rdata, ack, err);
        check("t5_rw_rdata", rdata, 0);
        check("t5_rw_err", 32'(err), 0);
        rd_reg(8, 0, "t5_popcnt_clr");
        rd_reg(4, 32'h0000_0003, "t5_status");
        // 6: async reset during the fetch of the next word
        q.push_back(14'h0111); q.push_back(14'h0222); q.push_back(14'h0333);
        rd_reg(0, data_word(w[12]), "t6_pop");
        #1 bus.sys_ren = 1;
        bus.sys_addr = 20'h8;
        @(posedge clk);
        #1 bus.sys_ren = 0;
        check("t6_pre_rdata", bus.sys_rdata, 1);
        #2 rst = 1;
        #1 check("t6_rst_rd_en", 32'(bus.fifo_rd_en), 0);
        check("t6_rst_ack", 32'(bus.sys_ack), 0);
        check("t6_rst_rdata", bus.sys_rdata, 0);
        @(posedge clk);
        #3 rst = 0;
        cycles(6);
        rd_reg(0, 32'h8000_0222, "t6_after_rst");
        bus_op(0, 1, 20'h10, 0, rdata, ack, err);
        check("t6_unmapped_err", 32'(err), 1);
        check("t6_unmapped_rdata", rdata, 0);
        // randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (q.size() < 24 && $urandom_range(0, 3) == 0) q.push_back(14'($urandom));
            r = $urandom_range(0, 15);
            bus.sys_ren  = r inside {[4:9], 13};
            bus.sys_wen  = r inside {[10:12], 13};
            bus.sys_addr = addrs[$urandom_range(0, 9)];
            bus.sys_wdata = $urandom;
            if ($urandom_range(0, 7) != 0) bus.sys_wdata[0] = 1'b0;
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1;
                @(posedge clk);
                #3 rst = 0;
            end
        end
        #1 bus.sys_ren = 0;
        bus.sys_wen = 0;
        cycles(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
